hazard_detect_unit: RTL
=======================

# hazard_detect_unit

Producer of the per-operand forwarding select codes consumed by the EX-stage forwarding mux, plus load-use stall generation for the 4-stage (IF/ID/EX/WB) core. Tracks the destination register of the instructions in EX and WB in a two-slot scoreboard and compares it against the source registers of the instruction in ID. Select codes are registered so they are valid during the consumer's EX cycle.

## Interface
Parameters:
- REG_AW, 5, register-address width
- CNT_W, 16, width of the load-use stall counter

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous, active-low reset
- hold  in  1  global pipeline freeze (e.g. memory wait); all state holds
- flush  in  1  branch-mispredict flush of the ID instruction
- id_valid  in  1  ID stage holds a real instruction
- id_rs1, id_rs2  in  REG_AW  source register addresses in ID
- id_rs1_used, id_rs2_used  in  1  operand actually read by the instruction
- id_rd  in  REG_AW  destination register of the ID instruction
- id_regwrite  in  1  ID instruction writes rd
- id_memread  in  1  ID instruction is a load (result arrives via memtoreg path)
- rs1_hazard, rs2_hazard  out  2  forwarding select: 00 register file, 01 ALU result, 10 writeback (memtoreg) data, 11 never driven
- stall  out  1  load-use stall: freeze IF/ID, inject bubble into EX
- load_use_cnt  out  CNT_W  saturating count of stall cycles

## Operation
- Scoreboard slots ex_slot, wb_slot: {valid, rd, regwrite, memread}. Slot "writes" only if valid && regwrite && rd != 0.
- Match per operand (rsN_used && rsN == slot.rd && slot writes). x0 never matches.
- Combinational select for operand N: ex_slot match && !ex_slot.memread -> 01; else wb_slot match -> 10; else 00. EX slot has priority over WB slot (younger producer wins).
- stall = id_valid && !flush && ex_slot writes && ex_slot.memread && (rs1 match or rs2 match on ex_slot).
- Per cycle, when hold=0:
  - wb_slot <= ex_slot
  - ex_slot <= bubble (valid=0) if stall || flush || !id_valid, else ID fields
  - rsN_hazard <= 00 if stall || flush || !id_valid, else combinational select
  - load_use_cnt += 1 if stall, saturating at all-ones
- hold=1: every register holds; stall still evaluated combinationally from held state.
- After a load-use stall the load moves to wb_slot while the consumer stays in ID; next cycle it matches wb_slot and gets 10.
- flush and stall together: flush wins (bubble, codes 00, counter not incremented).

## Timing
- Reset (async assert, sync release on clk): slots invalid, rs1_hazard=rs2_hazard=00, load_use_cnt=0; stall=0 as a consequence.
- Select latency: 1 cycle, computed in ID, presented in the consumer's EX cycle.
- stall: combinational, same cycle as the ID instruction; exactly one cycle per load-use pair.
- Reset mid-operation discards all in-flight hazard state; no partial codes after release.

## Structure
- Shared package: forwarding-select constants (FWD_REG=00, FWD_ALU=01, FWD_WB=10) and the scoreboard slot struct, shared with the forwarding mux.
- One natural sub-module: hdu_operand_cmp (per-operand match/priority logic), instantiated twice.

## Test plan
- add x5 then add x6,x5,x1 back-to-back -> EX cycle of consumer: rs1_hazard=01, rs2_hazard=00, stall never 1.
- add x5; nop; sub x7,x2,x5 -> rs2_hazard=10 in sub's EX cycle.
- lw x5; add x6,x5,x5 -> stall=1 for exactly one cycle, bubble into EX, then rs1_hazard=rs2_hazard=10, load_use_cnt=1.
- producer writes x0, consumer reads x0 -> codes 00, no stall; same producer with id_rs1_used=0 -> 00.
- add x5; add x5; add x6,x5,x0 -> rs1_hazard=01 (EX priority over WB).
- lw x5 in EX with dependent in ID and flush=1 -> stall=0, codes 00 next cycle, counter unchanged; hold=1 for 3 cycles mid-sequence -> outputs and counter frozen; rst_n low mid-stream -> all outputs 00/0 immediately.

Source files
------------

// File: rtl/hazard_detect_unit_pkg.sv
// Shared definitions for the hazard detect unit and the EX-stage forwarding mux:
// forwarding-select codes and the scoreboard slot record.
package hazard_detect_unit_pkg;

    // Slot rd field is sized for the widest register file in use; narrower
    // addresses are zero-extended into it.
    localparam int unsigned SLOT_RD_W = 8;

    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_ALU = 2'b01,
        FWD_WB  = 2'b10
    } fwd_sel_e;

    typedef struct packed {
        logic                 valid;
        logic [SLOT_RD_W-1:0] rd;
        logic                 regwrite;
        logic                 memread;
    } hdu_slot_t;

    function automatic logic slot_writes(input hdu_slot_t s);
        return s.valid && s.regwrite && (s.rd != '0);
    endfunction

endpackage

// File: rtl/hdu_operand_cmp.sv
// Per-operand scoreboard match and forwarding priority (EX slot beats WB slot).
module hdu_operand_cmp
    import hazard_detect_unit_pkg::*;
#(
    parameter int unsigned REG_AW = 5
) (
    input  logic [REG_AW-1:0] rs,
    input  logic              rs_used,
    input  hdu_slot_t         ex_slot,
    input  hdu_slot_t         wb_slot,
    output logic [1:0]        sel,
    output logic              ex_load_match
);

    logic [SLOT_RD_W-1:0] rs_ext;
    logic                 ex_match;
    logic                 wb_match;
    fwd_sel_e             sel_e;

    always_comb begin
        rs_ext   = SLOT_RD_W'(rs);
        ex_match = rs_used && slot_writes(ex_slot) && (ex_slot.rd == rs_ext);
        wb_match = rs_used && slot_writes(wb_slot) && (wb_slot.rd == rs_ext);

        // A load in EX cannot forward yet; fall back to WB (the stall covers it).
        sel_e = FWD_REG;
        if (ex_match && !ex_slot.memread) begin
            sel_e = FWD_ALU;
        end else if (wb_match) begin
            sel_e = FWD_WB;
        end

        sel           = sel_e;
        ex_load_match = ex_match && ex_slot.memread;
    end

endmodule

// File: rtl/hazard_detect_unit.sv
// Two-slot scoreboard producing registered forwarding selects and load-use stall
// for the 4-stage IF/ID/EX/WB core.
module hazard_detect_unit
    import hazard_detect_unit_pkg::*;
#(
    parameter int unsigned REG_AW = 5,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hold,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_regwrite,
    input  logic              id_memread,
    output logic [1:0]        rs1_hazard,
    output logic [1:0]        rs2_hazard,
    output logic              stall,
    output logic [CNT_W-1:0]  load_use_cnt
);

    hdu_slot_t  ex_slot;
    hdu_slot_t  wb_slot;
    hdu_slot_t  id_slot;
    logic [1:0] rs1_sel;
    logic [1:0] rs2_sel;
    logic       rs1_ld;
    logic       rs2_ld;
    logic       bubble;

    hdu_operand_cmp #(.REG_AW(REG_AW)) u_cmp_rs1 (
        .rs            (id_rs1),
        .rs_used       (id_rs1_used),
        .ex_slot       (ex_slot),
        .wb_slot       (wb_slot),
        .sel           (rs1_sel),
        .ex_load_match (rs1_ld)
    );

    hdu_operand_cmp #(.REG_AW(REG_AW)) u_cmp_rs2 (
        .rs            (id_rs2),
        .rs_used       (id_rs2_used),
        .ex_slot       (ex_slot),
        .wb_slot       (wb_slot),
        .sel           (rs2_sel),
        .ex_load_match (rs2_ld)
    );

    always_comb begin
        id_slot          = '0;
        id_slot.valid    = 1'b1;
        id_slot.rd       = SLOT_RD_W'(id_rd);
        id_slot.regwrite = id_regwrite;
        id_slot.memread  = id_memread;

        // flush overrides stall so a squashed instruction never counts.
        stall  = id_valid && !flush && (rs1_ld || rs2_ld);
        bubble = stall || flush || !id_valid;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_slot      <= '0;
            wb_slot      <= '0;
            rs1_hazard   <= FWD_REG;
            rs2_hazard   <= FWD_REG;
            load_use_cnt <= '0;
        end else if (!hold) begin
            wb_slot    <= ex_slot;
            ex_slot    <= bubble ? '0 : id_slot;
            rs1_hazard <= bubble ? FWD_REG : rs1_sel;
            rs2_hazard <= bubble ? FWD_REG : rs2_sel;
            if (stall && (load_use_cnt != '1)) begin
                load_use_cnt <= load_use_cnt + CNT_W'(1);
            end
        end
    end

endmodule
